// File: rtl/fsmc_bus_master.sv
// MCU-side initiator for the asynchronous SRAM-style FSMC bus: single-beat reads/writes
// on NE1 (CPU space) or NE2 (PPU space) with programmable setup/data/hold and NWAIT stretch.
module fsmc_bus_master #(
   parameter int ADDSET       = 2,
   parameter int DATAST       = 4,
   parameter int HOLD         = 1,
   parameter int TIMEOUT_BITS = 10
) (
   input  logic        master_clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic        cmd_ppu,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic        resp_timeout,
   output logic        ne1,
   output logic        ne2,
   output logic        noe,
   output logic        nwe,
   output logic [15:0] addr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   input  logic        nwait
);

   localparam int CW = $clog2(ADDSET + DATAST + HOLD + 1);
   localparam logic [CW-1:0] ADD_LAST = CW'(ADDSET - 1);
   localparam logic [CW-1:0] DAT_LAST = CW'(DATAST - 1);
   localparam logic [CW-1:0] HLD_LAST = CW'(HOLD - 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [TIMEOUT_BITS-1:0] wcnt;
   logic                    wr_q;
   logic                    ppu_q;
   logic [7:0]              rdata_q;
   logic                    timeout_q;
   logic                    nwait_meta;
   logic                    nwait_s;

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         nwait_meta <= 1'b1;
         nwait_s    <= 1'b1;
      end else begin
         nwait_meta <= nwait;
         nwait_s    <= nwait_meta;
      end
   end

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wcnt         <= '0;
         wr_q         <= 1'b0;
         ppu_q        <= 1'b0;
         rdata_q      <= 8'h00;
         timeout_q    <= 1'b0;
         cmd_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_rdata   <= 8'h00;
         resp_timeout <= 1'b0;
         ne1          <= 1'b1;
         ne2          <= 1'b1;
         noe          <= 1'b1;
         nwe          <= 1'b1;
         addr         <= 16'h0000;
         data_out     <= 8'h00;
         data_oe      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               resp_valid <= 1'b0;
               if (cmd_valid) begin
                  wr_q      <= cmd_write;
                  ppu_q     <= cmd_ppu;
                  addr      <= cmd_addr;
                  data_out  <= cmd_wdata;
                  data_oe   <= cmd_write;
                  ne1       <= cmd_ppu;
                  ne2       <= ~cmd_ppu;
                  cnt       <= '0;
                  cmd_ready <= 1'b0;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == ADD_LAST) begin
                  noe   <= wr_q;
                  nwe   <= ~wr_q;
                  cnt   <= '0;
                  wcnt  <= '0;
                  state <= S_ACCESS;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACCESS: begin
               // nwait_s is only looked at once the minimum strobe width has elapsed
               if (cnt != DAT_LAST) begin
                  cnt <= cnt + 1'b1;
               end else if (nwait_s) begin
                  rdata_q   <= wr_q ? 8'h00 : data_in;
                  timeout_q <= 1'b0;
                  noe       <= 1'b1;
                  nwe       <= 1'b1;
                  cnt       <= '0;
                  state     <= S_HOLD;
               end else if (&wcnt) begin
                  rdata_q   <= 8'hFF;
                  timeout_q <= 1'b1;
                  noe       <= 1'b1;
                  nwe       <= 1'b1;
                  cnt       <= '0;
                  state     <= S_HOLD;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (cnt == HLD_LAST) begin
                  ne1          <= 1'b1;
                  ne2          <= 1'b1;
                  data_oe      <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_rdata   <= rdata_q;
                  resp_timeout <= timeout_q;
                  state        <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               // both chip selects stay high here, giving the responder its NE-inactive gap
               resp_valid <= 1'b0;
               cmd_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Directed bench for fsmc_bus_master: a negedge monitor tallies bus activity, and each
// scenario task compares the tallies against hand-computed cycle counts and data.
module tb_fsmc_bus_master;
   logic        master_clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic        cmd_ppu = 1'b0;
   logic [15:0] cmd_addr = 16'h0000;
   logic [7:0]  cmd_wdata = 8'h00;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_timeout;
   logic        ne1, ne2, noe, nwe;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in = 8'h00;
   logic        nwait = 1'b1;

   fsmc_bus_master dut (
      .master_clock(master_clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_ppu(cmd_ppu), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
      .ne1(ne1), .ne2(ne2), .noe(noe), .nwe(nwe), .addr(addr),
      .data_out(data_out), .data_oe(data_oe), .data_in(data_in), .nwait(nwait)
   );

   always #5 master_clock = ~master_clock;

   int checks = 0;
   int errors = 0;

   logic        mon = 1'b0;
   int          n_ne1, n_ne2, n_noe, n_nwe, n_oe, n_oe_bad, n_addr_bad;
   int          n_bad, n_fall, n_resp, n_ready_bad;
   logic        prev_low, ne_low;
   logic [7:0]  got_rdata;
   logic        got_tmo;
   logic        exp_wr;
   logic [15:0] exp_addr;
   logic [7:0]  exp_wd;

   always @(negedge master_clock) begin
      if (mon) begin
         ne_low = !ne1 || !ne2;
         if (!ne1) n_ne1++;
         if (!ne2) n_ne2++;
         if (!noe) n_noe++;
         if (!nwe) n_nwe++;
         if (data_oe) n_oe++;
         if (data_oe !== (ne_low && exp_wr)) n_oe_bad++;
         if (data_oe && data_out !== exp_wd) n_oe_bad++;
         if (ne_low && addr !== exp_addr) n_addr_bad++;
         if ((!ne1 && !ne2) || (!noe && !nwe) || ((!noe || !nwe) && !ne_low)) n_bad++;
         if (ne_low && !prev_low) n_fall++;
         prev_low = ne_low;
         if (resp_valid) begin
            n_resp++;
            got_rdata = resp_rdata;
            got_tmo   = resp_timeout;
            if (!(ne1 && ne2 && noe && nwe && !data_oe)) n_bad++;
         end
         if (cmd_ready && (ne_low || resp_valid)) n_ready_bad++;
      end
   end

   task automatic clr_mon();
      n_ne1 = 0; n_ne2 = 0; n_noe = 0; n_nwe = 0; n_oe = 0; n_oe_bad = 0;
      n_addr_bad = 0; n_bad = 0; n_fall = 0; n_resp = 0; n_ready_bad = 0;
      prev_low = 1'b0; got_rdata = 8'h00; got_tmo = 1'b0; mon = 1'b1;
   endtask

   // Presents one command; returns #1 after the accepting edge with cmd_valid dropped.
   task automatic start(input logic w, input logic p, input logic [15:0] a, input logic [7:0] wd);
      @(posedge master_clock); #1;
      clr_mon();
      exp_wr = w; exp_addr = a; exp_wd = wd;
      cmd_write = w; cmd_ppu = p; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
      @(posedge master_clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input int target, input int maxc, input string name);
      int i;
      for (i = 0; i < maxc; i++) begin
         @(posedge master_clock);
         if (n_resp >= target) break;
      end
      checks++;
      if (n_resp < target) begin
         errors++;
         $display("FAIL %s resp wait expired: got %0d pulses, need %0d", name, n_resp, target);
      end
      repeat (2) @(posedge master_clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge master_clock);
      #1;
      checks++;
      if ({ne1, ne2, noe, nwe, data_oe} !== 5'b11110) begin
         errors++; $display("FAIL reset_bus got %b need 11110", {ne1, ne2, noe, nwe, data_oe});
      end
      checks++;
      if (addr !== 16'h0000 || data_out !== 8'h00) begin
         errors++; $display("FAIL reset_addr_data got %h/%h need 0000/00", addr, data_out);
      end
      checks++;
      if ({resp_valid, resp_rdata, resp_timeout} !== 10'h000) begin
         errors++; $display("FAIL reset_resp got %b/%h/%b need 0/00/0", resp_valid, resp_rdata, resp_timeout);
      end
      @(negedge master_clock); reset = 1'b0;
      @(posedge master_clock); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b need 1", cmd_ready);
      end
   endtask

   task automatic test_read_basic();
      nwait = 1'b1; data_in = 8'h5A;
      start(1'b0, 1'b0, 16'h8000, 8'h00);
      wait_resp(1, 50, "read_basic");
      checks++;
      if (n_ne1 != 7 || n_noe != 4) begin
         errors++; $display("FAIL read_basic_width ne1 %0d noe %0d need 7 4", n_ne1, n_noe);
      end
      checks++;
      if (n_ne2 != 0 || n_nwe != 0 || n_oe != 0 || n_addr_bad != 0 || n_bad != 0) begin
         errors++; $display("FAIL read_basic_idle ne2 %0d nwe %0d oe %0d addr_bad %0d bad %0d need all 0",
                            n_ne2, n_nwe, n_oe, n_addr_bad, n_bad);
      end
      checks++;
      if (got_rdata !== 8'h5A || got_tmo !== 1'b0 || n_resp != 1) begin
         errors++; $display("FAIL read_basic_resp got %h/%b/%0d need 5a/0/1", got_rdata, got_tmo, n_resp);
      end
      data_in = 8'h00;
      repeat (3) @(posedge master_clock);
      #1;
      checks++;
      if (resp_rdata !== 8'h5A || n_resp != 1) begin
         errors++; $display("FAIL read_basic_hold got %h/%0d need 5a/1", resp_rdata, n_resp);
      end
   endtask

   task automatic test_ppu_write();
      data_in = 8'hAA;
      start(1'b1, 1'b1, 16'h1234, 8'hC3);
      wait_resp(1, 50, "ppu_write");
      checks++;
      if (n_ne2 != 7 || n_ne1 != 0 || n_nwe != 4 || n_noe != 0) begin
         errors++; $display("FAIL ppu_write_width ne2 %0d ne1 %0d nwe %0d noe %0d need 7 0 4 0",
                            n_ne2, n_ne1, n_nwe, n_noe);
      end
      checks++;
      if (n_oe != 7 || n_oe_bad != 0 || n_addr_bad != 0 || n_bad != 0) begin
         errors++; $display("FAIL ppu_write_drive oe %0d oe_bad %0d addr_bad %0d bad %0d need 7 0 0 0",
                            n_oe, n_oe_bad, n_addr_bad, n_bad);
      end
      checks++;
      if (got_rdata !== 8'h00 || got_tmo !== 1'b0) begin
         errors++; $display("FAIL ppu_write_resp got %h/%b need 00/0", got_rdata, got_tmo);
      end
   endtask

   task automatic test_stretch();
      data_in = 8'h3C; nwait = 1'b1;
      start(1'b0, 1'b0, 16'h2001, 8'h00);
      repeat (3) @(posedge master_clock);
      #1 nwait = 1'b0;
      repeat (19) @(posedge master_clock);
      #1 begin nwait = 1'b1; data_in = 8'h96; end
      wait_resp(1, 50, "stretch");
      checks++;
      if (n_noe != 23 || n_ne1 != 26) begin
         errors++; $display("FAIL stretch_width noe %0d ne1 %0d need 23 26", n_noe, n_ne1);
      end
      checks++;
      if (got_rdata !== 8'h96 || got_tmo !== 1'b0 || n_bad != 0) begin
         errors++; $display("FAIL stretch_resp got %h/%b bad %0d need 96/0/0", got_rdata, got_tmo, n_bad);
      end
   endtask

   task automatic test_timeout();
      data_in = 8'h11; nwait = 1'b0;
      start(1'b0, 1'b0, 16'h0F0F, 8'h00);
      wait_resp(1, 1200, "timeout");
      nwait = 1'b1;
      checks++;
      if (n_noe != 1027 || n_ne1 != 1030) begin
         errors++; $display("FAIL timeout_width noe %0d ne1 %0d need 1027 1030", n_noe, n_ne1);
      end
      checks++;
      if (got_rdata !== 8'hFF || got_tmo !== 1'b1) begin
         errors++; $display("FAIL timeout_resp got %h/%b need ff/1", got_rdata, got_tmo);
      end
      checks++;
      if (n_bad != 0 || {ne1, ne2, noe, nwe} !== 4'b1111) begin
         errors++; $display("FAIL timeout_bus bad %0d pins %b need 0 1111", n_bad, {ne1, ne2, noe, nwe});
      end
   endtask

   task automatic test_reset_mid();
      nwait = 1'b1;
      start(1'b1, 1'b0, 16'h00F0, 8'h77);
      repeat (3) @(posedge master_clock);
      @(negedge master_clock);
      checks++;
      if (nwe !== 1'b0) begin
         errors++; $display("FAIL reset_mid_pre nwe %b need 0", nwe);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({nwe, ne1, data_oe, resp_valid} !== 4'b1100) begin
         errors++; $display("FAIL reset_mid_now got %b need 1100", {nwe, ne1, data_oe, resp_valid});
      end
      @(negedge master_clock); reset = 1'b0;
      data_in = 8'hE1;
      start(1'b0, 1'b0, 16'h4321, 8'h00);
      wait_resp(1, 50, "reset_mid_read");
      checks++;
      if (n_ne1 != 7 || n_noe != 4 || got_rdata !== 8'hE1 || got_tmo !== 1'b0) begin
         errors++; $display("FAIL reset_mid_read ne1 %0d noe %0d data %h tmo %b need 7 4 e1 0",
                            n_ne1, n_noe, got_rdata, got_tmo);
      end
   endtask

   task automatic test_back_to_back();
      int acc;
      int i;
      acc = 0;
      data_in = 8'h24; nwait = 1'b1;
      @(posedge master_clock); #1;
      clr_mon();
      exp_wr = 1'b0; exp_addr = 16'h0042; exp_wd = 8'h00;
      cmd_write = 1'b0; cmd_ppu = 1'b0; cmd_addr = 16'h0042; cmd_valid = 1'b1;
      for (i = 0; i < 100; i++) begin
         @(negedge master_clock);
         if (cmd_ready) acc++;
         if (acc == 3) break;
      end
      @(posedge master_clock); #1;
      cmd_valid = 1'b0;
      checks++;
      if (acc != 3) begin
         errors++; $display("FAIL b2b_accept got %0d need 3", acc);
      end
      wait_resp(3, 60, "b2b");
      repeat (10) @(posedge master_clock);
      #1;
      checks++;
      if (n_resp != 3 || n_fall != 3 || n_ne1 != 21) begin
         errors++; $display("FAIL b2b_count resp %0d falls %0d ne1 %0d need 3 3 21", n_resp, n_fall, n_ne1);
      end
      checks++;
      if (n_ready_bad != 0 || n_bad != 0 || got_rdata !== 8'h24) begin
         errors++; $display("FAIL b2b_ready ready_bad %0d bad %0d data %h need 0 0 24",
                            n_ready_bad, n_bad, got_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_ppu_write();
      test_stretch();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      mon = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
